// File: rtl/load_store_unit_if.sv
// Bundles the execute-stage handshake and the memory-side bus of the load/store unit.
// The unit connects through the slave modport.
// The master modport is the complementary view, used by whatever drives the unit.
interface load_store_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            is_load;
    logic            is_store;
    logic [2:0]      fn3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic            err;
    logic [XLEN-1:0] rdata;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  start, is_load, is_store, fn3, addr, wdata, mem_ack, mem_rdata,
        output busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output start, is_load, is_store, fn3, addr, wdata, mem_ack, mem_rdata,
        input  busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one memory op in flight.
// The unit captures the op on start, checks the fn3 encoding and the alignment, and
// then either faults at once or issues a single word-aligned request with byte strobes.
// Load data is extracted, extended and registered when mem_ack arrives.
module load_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      fn3_q;
    logic            store_q;
    logic [XLEN-1:0] rdata_q;

    logic            accept;
    logic            legal;
    logic            aligned;
    logic [1:0]      off;
    logic [XLEN-1:0] rd_byte_sh;
    logic [XLEN-1:0] rd_half_sh;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] load_ext;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata_lane;

    assign accept = (state_q == IDLE) && bus.start && (bus.is_load ^ bus.is_store);
    assign off    = addr_q[1:0];

    // Decode legality and alignment of the op presented on the input side.
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        case (bus.fn3)
            3'b000:         legal = 1'b1;
            3'b001:         legal = 1'b1;
            3'b010:         legal = 1'b1;
            3'b100, 3'b101: legal = bus.is_load;
            default:        legal = 1'b0;
        endcase
        if (bus.fn3[1:0] == 2'b01 && bus.addr[0])
            aligned = 1'b0;
        if (bus.fn3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
            aligned = 1'b0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (legal && aligned) ? REQ : FAULT;
            REQ:     if (bus.mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Capture the op on the accepted start cycle so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            fn3_q   <= '0;
            store_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            fn3_q   <= bus.fn3;
            store_q <= bus.is_store;
        end
    end

    // Lane extraction and sign/zero extension of the returned read word.
    always_comb begin
        rd_byte_sh = bus.mem_rdata >> {off, 3'b000};
        rd_half_sh = bus.mem_rdata >> {off[1], 4'b0000};
        rd_byte    = rd_byte_sh[7:0];
        rd_half    = rd_half_sh[15:0];
        case (fn3_q)
            3'b000:  load_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, rd_byte};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, rd_half};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // Load result register, updated only when a load completes.
    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= '0;
        else if (state_q == REQ && bus.mem_ack && !store_q)
            rdata_q <= load_ext;
    end

    // Store strobes and lane replication from the captured op.
    always_comb begin
        strb       = 4'b0000;
        wdata_lane = wdata_q;
        if (store_q) begin
            case (fn3_q[1:0])
                2'b00: begin
                    strb       = 4'b0001 << off;
                    wdata_lane = {(XLEN/8){wdata_q[7:0]}};
                end
                2'b01: begin
                    strb       = 4'b0011 << off;
                    wdata_lane = {(XLEN/16){wdata_q[15:0]}};
                end
                default: begin
                    strb       = 4'b1111;
                    wdata_lane = wdata_q;
                end
            endcase
        end
    end

    // Outputs: the memory bus is driven only in REQ and forced to zero otherwise.
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE) || (state_q == FAULT);
        bus.err       = (state_q == FAULT);
        bus.rdata     = rdata_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = 4'b0000;
        if (state_q == REQ) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = store_q;
            bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
            bus.mem_wdata = store_q ? wdata_lane : '0;
            bus.mem_wstrb = strb;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// A table of single ops with hand-computed bus and result values, followed by
// sequences for start-while-busy, stray acks, and reset during a request.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  fn3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int unsigned dly;
        logic        flt;
        logic [31:0] e_maddr;
        logic        e_we;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.is_load   = 1'b0;
        bus.is_store  = 1'b0;
        bus.fn3       = 3'b000;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string n;
        n = $sformatf("v%0d", idx);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.is_load  = v.ld;
        bus.is_store = v.st;
        bus.fn3      = v.fn3;
        bus.addr     = v.addr;
        bus.wdata    = v.wdata;
        @(negedge clk);
        bus.start = 1'b0;
        bus.addr  = 32'hFFFF_FFFF;
        bus.wdata = 32'h5555_5555;
        if (v.flt) begin
            chk({n, ".flt_done"}, {31'd0, bus.done}, 32'd1);
            chk({n, ".flt_err"}, {31'd0, bus.err}, 32'd1);
            chk({n, ".flt_req"}, {31'd0, bus.mem_req}, 32'd0);
            chk({n, ".flt_rdata"}, bus.rdata, v.e_rd);
        end else begin
            chk({n, ".req"}, {31'd0, bus.mem_req}, 32'd1);
            chk({n, ".maddr"}, bus.mem_addr, v.e_maddr);
            chk({n, ".we"}, {31'd0, bus.mem_we}, {31'd0, v.e_we});
            chk({n, ".strb"}, {28'd0, bus.mem_wstrb}, {28'd0, v.e_strb});
            chk({n, ".mwdata"}, bus.mem_wdata, v.e_wd);
            for (int unsigned i = 0; i < v.dly; i++) begin
                @(negedge clk);
                chk({n, ".wait_req"}, {31'd0, bus.mem_req}, 32'd1);
                chk({n, ".wait_done"}, {31'd0, bus.done}, 32'd0);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.mrd;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0BAD_0BAD;
            chk({n, ".done"}, {31'd0, bus.done}, 32'd1);
            chk({n, ".err"}, {31'd0, bus.err}, 32'd0);
            chk({n, ".req_off"}, {31'd0, bus.mem_req}, 32'd0);
            chk({n, ".maddr_off"}, bus.mem_addr, 32'd0);
            chk({n, ".rdata"}, bus.rdata, v.e_rd);
        end
        @(negedge clk);
        chk({n, ".idle_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({n, ".idle_done"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        // ld st fn3 addr wdata mem_rdata dly flt maddr we strb mwdata rdata
        vt[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, 1'b0, 32'h0000_0100, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80};
        vt[1]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 0, 1'b0, 32'h0000_0200, 1'b0, 4'b0000, 32'h0, 32'h0000_BEEF};
        vt[2]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h0000_00AB, 32'h0, 0, 1'b0, 32'h0000_1000, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0000_BEEF};
        vt[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234, 32'h0, 2, 1'b0, 32'h0000_1000, 1'b1, 4'b1100, 32'h1234_1234, 32'h0000_BEEF};
        vt[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_BEEF};
        vt[5]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0005, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_BEEF};
        vt[6]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_BEEF};
        vt[7]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0040, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0000_BEEF};
        vt[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0010, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
        vt[9]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0, 32'h8001_7FFF, 0, 1'b0, 32'h0000_0010, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001};
        vt[10] = '{1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'h0, 32'h0000_9A00, 1, 1'b0, 32'h0000_0010, 1'b0, 4'b0000, 32'h0, 32'h0000_009A};
        vt[11] = '{1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 0, 1'b0, 32'h0000_0020, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0000_009A};
        vt[12] = '{1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h1234_567F, 0, 1'b0, 32'h0000_0000, 1'b0, 4'b0000, 32'h0, 32'h0000_007F};
        vt[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h1111_8002, 0, 1'b0, 32'h0000_0000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8002};
        vt[14] = '{1'b1, 1'b0, 3'b101, 32'h0000_0001, 32'h0, 32'h0, 0, 1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8002};
        vt[15] = '{1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h1234_56C3, 32'h0, 0, 1'b0, 32'h0000_0000, 1'b1, 4'b1000, 32'hC3C3_C3C3, 32'hFFFF_8002};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.done", {31'd0, bus.done}, 32'd0);
        chk("rst.err", {31'd0, bus.err}, 32'd0);
        chk("rst.req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst.strb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("rst.rdata", bus.rdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vt[i], i);

        // both flags set: not accepted
        @(negedge clk);
        bus.start = 1'b1; bus.is_load = 1'b1; bus.is_store = 1'b1; bus.fn3 = 3'b010; bus.addr = 32'h40;
        @(negedge clk);
        idle_inputs();
        chk("both.busy", {31'd0, bus.busy}, 32'd0);
        chk("both.req", {31'd0, bus.mem_req}, 32'd0);

        // stray ack in IDLE
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray.busy", {31'd0, bus.busy}, 32'd0);
        chk("stray.done", {31'd0, bus.done}, 32'd0);
        chk("stray.rdata", bus.rdata, 32'hFFFF_8002);

        // start pulses while busy are ignored
        bus.start = 1'b1; bus.is_load = 1'b1; bus.fn3 = 3'b010; bus.addr = 32'h30;
        @(negedge clk);
        bus.is_load = 1'b1; bus.fn3 = 3'b000; bus.addr = 32'h99;
        chk("busy.maddr0", bus.mem_addr, 32'h30);
        @(negedge clk);
        chk("busy.maddr1", bus.mem_addr, 32'h30);
        chk("busy.req", {31'd0, bus.mem_req}, 32'd1);
        bus.start = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("busy.done", {31'd0, bus.done}, 32'd1);
        chk("busy.rdata", bus.rdata, 32'h1122_3344);
        @(negedge clk);
        chk("busy.idle", {31'd0, bus.busy}, 32'd0);

        // reset one cycle into REQ, with ack in the same and next cycle
        bus.start = 1'b1; bus.is_load = 1'b1; bus.fn3 = 3'b010; bus.addr = 32'h44;
        @(negedge clk);
        idle_inputs();
        chk("rreq.req", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst = 1'b0;
        chk("rreq.req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("rreq.done", {31'd0, bus.done}, 32'd0);
        chk("rreq.rdata", bus.rdata, 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("rreq.done2", {31'd0, bus.done}, 32'd0);
        chk("rreq.busy2", {31'd0, bus.busy}, 32'd0);
        chk("rreq.rdata2", bus.rdata, 32'd0);

        run_vec('{1'b1, 1'b0, 3'b010, 32'h0000_0048, 32'h0, 32'h0000_0005, 0, 1'b0,
                  32'h0000_0048, 1'b0, 4'b0000, 32'h0, 32'h0000_0005}, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
